uart_tx_buffered: RTL and testbench

//  Serial transmit side of the board UART link: accepts bytes from user logic, queues them in a small FIFO,
//  and shifts them out on the tx pin as 8N1 (configurable) frames at a fixed baud rate from an internal divider.

---
 rtl/uart_tx_buffered_pkg.sv | 19 +
 rtl/uart_tx_buffered_fifo.sv | 82 ++++++++
 rtl/uart_tx_buffered.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// oversampling ratio and the standard divider / stop-bit settings.
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } tx_state_e;

    localparam int OVERSAMPLE       = 16;
    localparam int DVSR_DEFAULT     = 163;   // 50 MHz / (16 * 19200)
    localparam int DVSR_BIT_DEFAULT = 8;
    localparam int SB_TICK_1        = 16;
    localparam int SB_TICK_1P5      = 24;
    localparam int SB_TICK_2        = 32;

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Small synchronous FIFO with registered full/empty flags; a write into a full
// FIFO is still accepted when a pop happens in the same cycle.
module uart_tx_buffered_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         full,
    output logic         empty
);

    logic [B-1:0] mem_r [2**W];
    logic [W-1:0] w_ptr_r, r_ptr_r, w_ptr_next_s, r_ptr_next_s, w_succ_s, r_succ_s;
    logic         full_r, empty_r, full_next_s, empty_next_s;
    logic         wr_en_s, rd_en_s;

    assign rd_en_s  = rd & ~empty_r;
    assign wr_en_s  = wr & (~full_r | rd_en_s);
    assign w_succ_s = w_ptr_r + W'(1);
    assign r_succ_s = r_ptr_r + W'(1);
    assign r_data   = mem_r[r_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[w_ptr_r] <= w_data;
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr_r <= {W{1'b0}};
            r_ptr_r <= {W{1'b0}};
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            w_ptr_r <= w_ptr_next_s;
            r_ptr_r <= r_ptr_next_s;
            full_r  <= full_next_s;
            empty_r <= empty_next_s;
        end
    end

    // Next pointers and flags; simultaneous write and pop leaves the fill level unchanged
    always_comb begin
        w_ptr_next_s = w_ptr_r;
        r_ptr_next_s = r_ptr_r;
        full_next_s  = full_r;
        empty_next_s = empty_r;
        case ({wr_en_s, rd_en_s})
            2'b01: begin
                r_ptr_next_s = r_succ_s;
                full_next_s  = 1'b0;
                empty_next_s = (r_succ_s == w_ptr_r);
            end
            2'b10: begin
                w_ptr_next_s = w_succ_s;
                empty_next_s = 1'b0;
                full_next_s  = (w_succ_s == r_ptr_r);
            end
            2'b11: begin
                w_ptr_next_s = w_succ_s;
                r_ptr_next_s = r_succ_s;
            end
            default: begin
                w_ptr_next_s = w_ptr_r;
                r_ptr_next_s = r_ptr_r;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter with input FIFO: pops queued bytes and shifts them out as
// start / DBIT data (LSB first) / stop frames timed by an oversample-tick divider.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = SB_TICK_1,
    parameter int DVSR     = DVSR_DEFAULT,
    parameter int DVSR_BIT = DVSR_BIT_DEFAULT,
    parameter int FIFO_W   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_uart,
    input  logic [7:0] w_data,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       tx_done_tick,
    output logic       tx
);

    localparam int                N_W       = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [4:0]        S_LAST    = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]        STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [N_W-1:0]    N_LAST    = N_W'(DBIT - 1);
    localparam logic [DVSR_BIT-1:0] DIV_LAST = DVSR_BIT'(DVSR - 1);

    tx_state_e           state_r, state_next_s;
    logic [DVSR_BIT-1:0] div_r, div_next_s;
    logic [4:0]          s_r, s_next_s;
    logic [N_W-1:0]      n_r, n_next_s;
    logic [DBIT-1:0]     b_r, b_next_s;
    logic                tx_r, tx_next_s;
    logic                done_r, done_next_s;
    logic                busy_r;
    logic                s_tick_s, pop_s, fifo_empty_s, fifo_full_s;
    logic [7:0]          fifo_r_data_s;

    uart_tx_buffered_fifo #(.B(8), .W(FIFO_W)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_uart),
        .rd     (pop_s),
        .w_data (w_data),
        .r_data (fifo_r_data_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    assign s_tick_s     = (div_r == DIV_LAST);
    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign tx_done_tick = done_r;
    assign tx_full      = fifo_full_s;

    // State, counters, shift register and registered pin outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            div_r   <= {DVSR_BIT{1'b0}};
            s_r     <= 5'd0;
            n_r     <= {N_W{1'b0}};
            b_r     <= {DBIT{1'b0}};
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            div_r   <= div_next_s;
            s_r     <= s_next_s;
            n_r     <= n_next_s;
            b_r     <= b_next_s;
            tx_r    <= tx_next_s;
            done_r  <= done_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Baud divider: parked at zero while idle so every frame starts phase-aligned
    always_comb begin
        if (state_r == ST_IDLE) begin
            div_next_s = {DVSR_BIT{1'b0}};
        end else if (s_tick_s) begin
            div_next_s = {DVSR_BIT{1'b0}};
        end else begin
            div_next_s = div_r + DVSR_BIT'(1);
        end
    end

    // Frame sequencing; tx_next_s reflects the current state so the pin lags one clock
    always_comb begin
        state_next_s = state_r;
        s_next_s     = s_r;
        n_next_s     = n_r;
        b_next_s     = b_r;
        tx_next_s    = 1'b1;
        done_next_s  = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    b_next_s     = fifo_r_data_s[DBIT-1:0];
                    pop_s        = 1'b1;
                    s_next_s     = 5'd0;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_next_s = 1'b0;
                if (s_tick_s) begin
                    if (s_r == S_LAST) begin
                        s_next_s     = 5'd0;
                        n_next_s     = {N_W{1'b0}};
                        state_next_s = ST_DATA;
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            ST_DATA: begin
                tx_next_s = b_r[0];
                if (s_tick_s) begin
                    if (s_r == S_LAST) begin
                        s_next_s = 5'd0;
                        b_next_s = b_r >> 1;
                        if (n_r == N_LAST) begin
                            state_next_s = ST_STOP;
                        end else begin
                            n_next_s = n_r + N_W'(1);
                        end
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            ST_STOP: begin
                tx_next_s = 1'b1;
                if (s_tick_s) begin
                    if (s_r == STOP_LAST) begin
                        done_next_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        s_next_s = s_r + 5'd1;
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a frame-level model (queue plus
// cycle-in-frame counter) is compared every cycle, and an independent serial
// decoder recovers the bytes on tx for directed and random traffic.
module tb_uart_tx_buffered;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int DVSR     = 4;
    localparam int DVSR_BIT = 3;
    localparam int FIFO_W   = 2;
    localparam int DEPTH    = 1 << FIFO_W;
    localparam int BITCLK   = 16 * DVSR;
    localparam int FRAME    = (1 + DBIT) * BITCLK + SB_TICK * DVSR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_uart = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       tx_full, tx_busy, tx_done_tick, tx;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // model state
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    bit         m_active = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int         m_t = 0;
    bit         m_done = 1'b0;
    bit         m_tx = 1'b1;

    // decoder / bookkeeping
    logic [7:0] rx[$];
    int         starts[$];
    logic [7:0] exp_q[$];
    int         rx_ferr = 0;
    int         done_cnt = 0;
    int         base_done = 0;
    bit         full_seen = 1'b0;

    uart_tx_buffered #(
        .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR), .DVSR_BIT(DVSR_BIT), .FIFO_W(FIFO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .tx_full      (tx_full),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a frame is FRAME clocks long; bit index = clocks-into-frame / BITCLK
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_t = 0;
            m_done = 1'b0;
            m_tx = 1'b1;
        end else begin
            bit pop;
            bit accept;
            int bitpos;
            if (!m_active) begin
                m_tx = 1'b1;
            end else begin
                bitpos = m_t / BITCLK;
                if (bitpos == 0) m_tx = 1'b0;
                else if (bitpos <= DBIT) m_tx = m_byte[bitpos-1];
                else m_tx = 1'b1;
            end
            pop = !m_active && (mq.size() > 0);
            accept = wr_uart && ((mq.size() < DEPTH) || pop);
            m_done = 1'b0;
            if (m_active) begin
                if (m_t == FRAME - 1) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_t++;
                end
            end else if (pop) begin
                m_byte = mq.pop_front();
                sent.push_back(m_byte);
                m_active = 1'b1;
                m_t = 0;
            end
            if (accept) mq.push_back(w_data);
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("tx", tx, m_tx);
        chk("tx_busy", tx_busy, m_active);
        chk("tx_done_tick", tx_done_tick, m_done);
        chk("tx_full", tx_full, mq.size() == DEPTH);
        if (tx_done_tick) done_cnt++;
        if (tx_full) full_seen = 1'b1;
    end

    // Independent serial decoder sampling mid-bit
    initial begin
        bit tx_prev;
        bit aborted;
        bit ok;
        int c0;
        int k;
        logic [7:0] b;
        tx_prev = 1'b1;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && tx_prev && !tx) begin
                c0 = cyc;
                aborted = 1'b0;
                ok = 1'b1;
                for (int off = 1; off <= 9 * BITCLK + BITCLK / 2; off++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (off % BITCLK == BITCLK / 2) begin
                        k = off / BITCLK;
                        if (k == 0) ok &= (tx == 1'b0);
                        else if (k <= DBIT) b[k-1] = tx;
                        else ok &= (tx == 1'b1);
                    end
                end
                if (!aborted) begin
                    starts.push_back(c0);
                    rx.push_back(b);
                    if (!ok) rx_ferr++;
                end
            end
            tx_prev = tx;
        end
    end

    task automatic clear_test();
        rx.delete();
        starts.delete();
        sent.delete();
        exp_q.delete();
        base_done = done_cnt;
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        wr_uart = 1'b1;
        w_data = d;
    endtask

    task automatic stop_writes();
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((m_active || mq.size() != 0 || tx_busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_idle_timeout", k >= budget, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        chk($sformatf("%s_frame_count", tag), rx.size(), exp_q.size());
        chk($sformatf("%s_done_count", tag), done_cnt - base_done, exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), rx[i], exp_q[i]);
        end
    endtask

    initial begin
        int write_edge;
        int k;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_full", tx_full, 0);
        chk("reset_done", tx_done_tick, 0);
        reset = 1'b0;

        // single byte, latency and bit pattern
        clear_test();
        send(8'h55);
        write_edge = cyc + 1;
        stop_writes();
        wait_idle(5000);
        exp_q.push_back(8'h55);
        check_rx("t1");
        chk("t1_latency", starts.size() > 0 ? starts[0] - write_edge : -1, 2);
        chk("t1_busy_after", tx_busy, 0);

        // back-to-back frames
        clear_test();
        send(8'hA3); send(8'h00); send(8'hFF);
        stop_writes();
        wait_idle(5000);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        check_rx("t2");
        if (starts.size() == 3) begin
            chk("t2_gap01", starts[1] - starts[0], 641);
            chk("t2_gap12", starts[2] - starts[1], 641);
        end else begin
            chk("t2_start_count", starts.size(), 3);
        end

        // overflow: sixth byte dropped
        clear_test();
        full_seen = 1'b0;
        for (int d = 8'h10; d <= 8'h15; d++) send(8'(d));
        stop_writes();
        wait_idle(6000);
        for (int d = 8'h10; d <= 8'h14; d++) exp_q.push_back(8'(d));
        check_rx("t3");
        chk("t3_full_seen", full_seen, 1);

        // reset during data bit 3
        clear_test();
        send(8'h0F); send(8'h33);
        stop_writes();
        k = 0;
        while (!(m_active && m_t >= 4 * BITCLK + 8) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("t4_reach_bit3_timeout", k >= 2000, 0);
        #2 reset = 1'b1;
        #1;
        chk("t4_tx_async", tx, 1);
        chk("t4_busy_async", tx_busy, 0);
        chk("t4_full_async", tx_full, 0);
        base_done = done_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx.delete();
        starts.delete();
        repeat (1500) @(negedge clk);
        chk("t4_no_frames", starts.size(), 0);
        chk("t4_no_done", done_cnt - base_done, 0);

        // write into full FIFO on the IDLE pop cycle
        clear_test();
        for (int d = 8'h20; d <= 8'h24; d++) send(8'(d));
        stop_writes();
        k = 0;
        while (!(!m_active && mq.size() == DEPTH) && k < 1500) begin
            @(negedge clk);
            k++;
        end
        chk("t5_pop_cycle_timeout", k >= 1500, 0);
        chk("t5_full_at_pop", tx_full, 1);
        wr_uart = 1'b1;
        w_data = 8'h25;
        stop_writes();
        wait_idle(8000);
        for (int d = 8'h20; d <= 8'h25; d++) exp_q.push_back(8'(d));
        check_rx("t5");

        // loopback-style decode
        clear_test();
        send(8'h41); send(8'h7E);
        stop_writes();
        wait_idle(5000);
        exp_q.push_back(8'h41); exp_q.push_back(8'h7E);
        check_rx("t6");

        // random traffic against the model's popped-byte list
        clear_test();
        repeat (12000) begin
            @(negedge clk);
            wr_uart = ($urandom_range(0, 99) < 2);
            w_data = 8'($urandom);
        end
        stop_writes();
        wait_idle(6000);
        exp_q = sent;
        check_rx("rand");

        chk("framing_errors", rx_ferr, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
